// File: rtl/fetch_decode_stage.sv
// IF stage + IF/ID register: ack->ifid_valid next cycle, 1 instr/cycle at zero-wait; id_stall parks a fetched word in a hold buffer.
// Optional counters perf_fetched/perf_bubbles exist only when FETCH_PERF_CNT_EN is defined.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [15:0] ifid_imm16
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + PC_INC;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    // Decode consumes the current word whenever it is not stalled.
    ifid_valid_d = ifid_valid_q & id_stall;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_valid) pc_d = redirect_pc;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (!id_stall || !ifid_valid_q) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_inc;
            pc_d         = pc_inc;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc_inc;
            pc_d         = pc_inc;
            state_d      = HOLD;
          end
        end else if (redirect_valid) begin
          // The address must stay stable until ack, so the target waits here.
          pending_pc_d = redirect_pc;
          state_d      = KILL;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (!id_stall) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = hold_instr_q;
          ifid_pc4_d   = hold_pc4_q;
          state_d      = FETCH;
        end
      end
      KILL: begin
        if (redirect_valid) pending_pc_d = redirect_pc;
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_pc : pending_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid && state_q != IDLE) ifid_valid_d = 1'b0;
  end

  always_comb begin
    imem_req   = (state_q == FETCH) || (state_q == KILL);
    imem_addr  = pc_q;
    ifid_valid = ifid_valid_q;
    ifid_instr = ifid_instr_q;
    ifid_pc4   = ifid_pc4_q;
    ifid_imm16 = ifid_instr_q[15:0];
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] bubbles_q, bubbles_d;
  logic        load_evt;

  always_comb begin
    load_evt  = !redirect_valid &&
                (((state_q == FETCH) && imem_ack && (!id_stall || !ifid_valid_q)) ||
                 ((state_q == HOLD) && !id_stall));
    fetched_d = fetched_q + (load_evt ? 32'd1 : 32'd0);
    bubbles_d = bubbles_q + ((state_q != IDLE && !ifid_valid_q) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fetched_q <= 32'h0;
      bubbles_q <= 32'h0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  // No performance counters in this build.
`endif

endmodule
